// File: rtl/updown_sweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
//   sweep_state_e : controller FSM states (idle, counting up, counting down, done).
//   DIR_UP/DIR_DN : value driven on the counter's up_down input for each direction.
package updown_sweep_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2,
        StDone = 2'd3
    } sweep_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updown_sweep_ctrl_turn_detect.sv
// sweep_turn_detect: combinational turn-point detection for the sweep controller.
// The counter moves on the same edge the controller decides on, so turns are
// detected one count early (lim-1 going up, 1 going down).
//   cnt_count   : current counter value
//   lim         : latched sweep peak
//   cnt_enable  : registered counter enable (a frozen count must not turn)
//   dir         : registered counter direction
//   turn_up_hit : the next edge lands on lim while counting up
//   turn_dn_hit : the next edge lands on 0 while counting down
module sweep_turn_detect
    import updown_sweep_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] cnt_count,
    input  logic [N-1:0] lim,
    input  logic         cnt_enable,
    input  logic         dir,
    output logic         turn_up_hit,
    output logic         turn_dn_hit
);

    logic [N-1:0] lim_m1;

    assign lim_m1      = lim - N'(1);
    assign turn_up_hit = cnt_enable && (dir == DIR_UP) && (cnt_count == lim_m1);
    assign turn_dn_hit = cnt_enable && (dir == DIR_DN) && (cnt_count == N'(1));

endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives an external N-bit up/down counter through triangular
// sweeps 0 -> lim -> 0, repeated cfg_sweeps times (0 = until abort).
// Optional build macro: SWEEP_PAUSE_EN adds the pause input.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start, abort        : host commands (start pulse accepted only in idle; abort level)
//   cfg_limit/cfg_sweeps: sweep peak and sweep count, latched on accepted start
//   pause               : freezes the sweep (SWEEP_PAUSE_EN only)
//   cnt_count/overflow  : monitored counter outputs
//   cnt_enable/up_down  : registered counter controls
//   busy/done/err       : status; err is sticky until the next accepted start
//   sweep_idx           : completed sweeps
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned C = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] cfg_limit,
    input  logic [C-1:0] cfg_sweeps,
`ifdef SWEEP_PAUSE_EN
    input  logic         pause,
`endif
    input  logic [N-1:0] cnt_count,
    input  logic         cnt_overflow,
    output logic         cnt_enable,
    output logic         cnt_up_down,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [C-1:0] sweep_idx
);

    sweep_state_e state_q, state_d;
    logic [N-1:0] lim_q, lim_d;
    logic [C-1:0] sweeps_q, sweeps_d;
    logic [C-1:0] idx_q, idx_d;
    logic         en_q, en_d;
    logic         dir_q, dir_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         turn_up_hit, turn_dn_hit;
    logic         in_sweep, ovf_hit, start_ok, last_sweep, pause_act;
    logic [C-1:0] idx_inc;

`ifdef SWEEP_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    sweep_turn_detect #(
        .N (N)
    ) u_turn_detect (
        .cnt_count   (cnt_count),
        .lim         (lim_q),
        .cnt_enable  (en_q),
        .dir         (dir_q),
        .turn_up_hit (turn_up_hit),
        .turn_dn_hit (turn_dn_hit)
    );

    assign in_sweep   = (state_q == StUp) || (state_q == StDown);
    assign ovf_hit    = in_sweep && cnt_overflow;
    assign start_ok   = start && (cfg_limit != '0) && (cnt_count == '0);
    assign idx_inc    = idx_q + C'(1);
    assign last_sweep = (sweeps_q != '0) && (idx_inc == sweeps_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort > overflow > turn.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StUp;
            StUp: begin
                if (ovf_hit)          state_d = StIdle;
                else if (turn_up_hit) state_d = StDown;
            end
            StDown: begin
                if (ovf_hit)          state_d = StIdle;
                else if (turn_dn_hit) state_d = last_sweep ? StDone : StUp;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Output / datapath next values.
    always_comb begin
        lim_d    = lim_q;
        sweeps_d = sweeps_q;
        idx_d    = idx_q;
        en_d     = en_q;
        dir_d    = dir_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    lim_d    = cfg_limit;
                    sweeps_d = cfg_sweeps;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    en_d     = 1'b1;
                    dir_d    = DIR_UP;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            StUp, StDown: begin
                if (ovf_hit) begin
                    err_d = 1'b1;
                    en_d  = 1'b0;
                    dir_d = DIR_UP;
                end else begin
                    en_d = !pause_act;
                    // A turn is still honoured when pause arrives on a moving edge:
                    // the counter steps on this edge regardless, so the direction
                    // must follow it.
                    if (turn_up_hit) dir_d = DIR_DN;
                    if (turn_dn_hit) begin
                        idx_d = idx_inc;
                        dir_d = DIR_UP;
                        if (last_sweep) en_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (abort) begin
            lim_d    = lim_q;
            sweeps_d = sweeps_q;
            idx_d    = idx_q;
            err_d    = err_q;
            en_d     = 1'b0;
            dir_d    = DIR_UP;
        end
        busy_d = (state_d == StUp) || (state_d == StDown);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q    <= '0;
            sweeps_q <= '0;
            idx_q    <= '0;
            en_q     <= 1'b0;
            dir_q    <= DIR_UP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lim_q    <= lim_d;
            sweeps_q <= sweeps_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cnt_enable  = en_q;
    assign cnt_up_down = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign sweep_idx   = idx_q;

endmodule
